imem_boot_loader: RTL and testbench

Byte-stream boot loader that fills the single-cycle processor's instruction memory and holds the core in reset until the load completes. It sits between an external byte source (UART receiver or bench driver) and the IF stage's instruction memory write port. It is the writer side of the instruction-fetch path: it places words that the IF stage later reads by PC. Each image is framed with a length header and an XOR checksum. The core is released from reset only on a clean load.

---
 rtl/imem_boot_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: parses a length-framed, XOR-checksummed image, writes
// little-endian words into instruction memory, and holds the core in reset until a clean load.
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [7:0]        xor_q, xor_d;
    logic              s_ready_q, s_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic [15:0]       len_full;

    assign xfer     = s_valid && s_ready_q;
    assign len_full = {s_data, len_q[7:0]};

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        xor_d        = xor_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        done_d       = done_q;
        err_d        = err_q;

        case (state_q)
            ST_LEN0: begin
                if (xfer) begin
                    len_d[7:0] = s_data;
                    xor_d      = xor_q ^ s_data;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (xfer) begin
                    len_d[15:8] = s_data;
                    xor_d       = xor_q ^ s_data;
                    if (32'(len_full) > DEPTH) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    xor_d      = xor_q ^ s_data;
                    asm_d      = {s_data, asm_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Fourth byte completes a word: first byte has shifted down to [7:0]
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        imem_wdata_d = asm_d;
                        word_cnt_d   = word_cnt_q + CNT_W'(1);
                        if (32'(word_cnt_q) + 32'd1 == 32'(len_q)) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (s_data == xor_q) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        s_ready_d = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                    (state_d == ST_DATA) || (state_d == ST_CSUM);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_LEN0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            xor_q        <= '0;
            s_ready_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            xor_q        <= xor_d;
            s_ready_q    <= s_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frames built from a word list by a small model, writes
// captured by a monitor and compared for address, data and cycle of appearance.
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [31:0]       exp_words[$];
    logic [7:0]        frame[$];
    int                xfer_cycle[$];
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                wr_cycle[$];

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Write monitor: records every strobe, checks 1-cycle width and >= 4-cycle spacing
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cycle.size() > 0) begin
                checks++;
                if (cycle - wr_cycle[$] < 4) begin
                    errors++;
                    $display("FAIL write_spacing: gap %0d cycles, required >= 4", cycle - wr_cycle[$]);
                end
            end
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cycle.push_back(cycle);
        end
        checks++;
        if (done === 1'b1 && cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL done_vs_cpu_reset: done=%b cpu_reset=%b, required never both high", done, cpu_reset);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: frame = LEN_LO LEN_HI, words little-endian, XOR of all prior bytes
    task automatic build_frame(input int n, input bit bad_csum);
        logic [7:0] x;
        logic [31:0] w;
        frame.delete();
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        foreach (exp_words[i]) begin
            w = exp_words[i];
            for (int b = 0; b < 4; b++) frame.push_back(w[8*b +: 8]);
        end
        x = 8'h00;
        foreach (frame[i]) x = x ^ frame[i];
        frame.push_back(bad_csum ? (x ^ 8'h01) : x);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        wr_cycle.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Sends frame[0..cnt-1]; a byte counts as sent when s_ready is high under s_valid
    task automatic drive(input bit throttle, input int cnt);
        int i;
        int guard;
        i = 0;
        guard = 0;
        xfer_cycle.delete();
        while (i < cnt && guard < 20000) begin
            guard++;
            if (throttle && $urandom_range(1, 0) == 0) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = frame[i];
                if (s_ready === 1'b1) begin
                    xfer_cycle.push_back(cycle + 1);
                    i++;
                end
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (i < cnt) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: sent %0d of %0d bytes", i, cnt);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        repeat (2) @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'h0 ||
            done !== 1'b0 || err !== 1'b0 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: rdy=%b we=%b a=%h d=%h done=%b err=%b cpu_rst=%b, required 0 0 0 0 0 0 1",
                     s_ready, imem_we, imem_addr, imem_wdata, done, err, cpu_reset);
        end
        reset   = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: s_ready=%b, required 1", s_ready);
        end
    endtask

    task automatic test_normal(input bit throttle, input bit bad_csum);
        apply_reset();
        exp_words = {32'h00073A03, 32'h00530AB3, 32'h01583023, 32'h01288863};
        build_frame(4, bad_csum);
        drive(throttle, frame.size());
        checks++;
        if (done !== !bad_csum || err !== bad_csum || cpu_reset !== bad_csum || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL normal_outcome(thr=%0d bad=%0d): done=%b err=%b cpu_rst=%b rdy=%b, required %b %b %b 0",
                     throttle, bad_csum, done, err, cpu_reset, s_ready, !bad_csum, bad_csum, bad_csum);
        end
        checks++;
        if (wr_addr.size() != 4) begin
            errors++;
            $display("FAIL normal_write_count: %0d writes, required 4", wr_addr.size());
        end
        for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
            checks++;
            if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_words[i] || wr_cycle[i] != xfer_cycle[4*i+5]) begin
                errors++;
                $display("FAIL normal_write[%0d]: addr=%h data=%h cyc=%0d, required %h %h %0d",
                         i, wr_addr[i], wr_data[i], wr_cycle[i], ADDR_W'(i), exp_words[i], xfer_cycle[4*i+5]);
            end
        end
    endtask

    task automatic test_oversize();
        apply_reset();
        exp_words.delete();
        build_frame(257, 1'b0);
        drive(1'b0, 2);
        checks++;
        if (err !== 1'b1 || s_ready !== 1'b0 || done !== 1'b0 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL oversize_err: err=%b rdy=%b done=%b cpu_rst=%b, required 1 0 0 1",
                     err, s_ready, done, cpu_reset);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (wr_addr.size() != 0 || err !== 1'b1) begin
            errors++;
            $display("FAIL oversize_terminal: writes=%0d err=%b, required 0 1", wr_addr.size(), err);
        end
    endtask

    task automatic test_len0();
        apply_reset();
        exp_words.delete();
        build_frame(0, 1'b0);
        drive(1'b0, frame.size());
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || err !== 1'b0 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL len0: done=%b cpu_rst=%b err=%b writes=%0d, required 1 0 0 0",
                     done, cpu_reset, err, wr_addr.size());
        end
    endtask

    task automatic test_len256();
        int bad;
        apply_reset();
        exp_words.delete();
        for (int i = 0; i < 256; i++) exp_words.push_back($urandom);
        build_frame(256, 1'b0);
        drive(1'b0, frame.size());
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || wr_addr.size() != 256) begin
            errors++;
            $display("FAIL len256_outcome: done=%b err=%b writes=%0d, required 1 0 256", done, err, wr_addr.size());
        end
        checks++;
        if (wr_addr.size() == 0 || wr_addr[$] !== 8'hFF) begin
            errors++;
            $display("FAIL len256_last_addr: last addr=%h, required ff", wr_addr.size() ? wr_addr[$] : '0);
        end
        bad = 0;
        for (int i = 0; i < wr_addr.size() && i < 256; i++)
            if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_words[i] || wr_cycle[i] != xfer_cycle[4*i+5]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL len256_writes: %0d words wrong, required 0", bad);
        end
    endtask

    task automatic test_random_loads();
        int n;
        bit bad_csum;
        for (int t = 0; t < 6; t++) begin
            apply_reset();
            n = $urandom_range(12, 1);
            bad_csum = 1'($urandom_range(1, 0));
            exp_words.delete();
            for (int i = 0; i < n; i++) exp_words.push_back($urandom);
            build_frame(n, bad_csum);
            drive(1'b1, frame.size());
            checks++;
            if (done !== !bad_csum || err !== bad_csum || wr_addr.size() != n) begin
                errors++;
                $display("FAIL random_load[%0d]: done=%b err=%b writes=%0d, required %b %b %0d",
                         t, done, err, wr_addr.size(), !bad_csum, bad_csum, n);
            end
            for (int i = 0; i < wr_addr.size() && i < n; i++) begin
                checks++;
                if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_words[i]) begin
                    errors++;
                    $display("FAIL random_write[%0d][%0d]: addr=%h data=%h, required %h %h",
                             t, i, wr_addr[i], wr_data[i], ADDR_W'(i), exp_words[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int cuts[2] = '{6, 8};
        foreach (cuts[c]) begin
            apply_reset();
            exp_words = {32'h00073A03, 32'h00530AB3, 32'h01583023, 32'h01288863};
            build_frame(4, 1'b0);
            drive(1'b0, cuts[c]);
            apply_reset();
            checks++;
            if (wr_addr.size() != 0) begin
                errors++;
                $display("FAIL midreset_no_write(cut=%0d): %0d writes during reset, required 0", cuts[c], wr_addr.size());
            end
            drive(1'b0, frame.size());
            checks++;
            if (done !== 1'b1 || err !== 1'b0 || wr_addr.size() != 4) begin
                errors++;
                $display("FAIL midreset_replay(cut=%0d): done=%b err=%b writes=%0d, required 1 0 4",
                         cuts[c], done, err, wr_addr.size());
            end
            for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
                checks++;
                if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== exp_words[i]) begin
                    errors++;
                    $display("FAIL midreset_write(cut=%0d)[%0d]: addr=%h data=%h, required %h %h",
                             cuts[c], i, wr_addr[i], wr_data[i], ADDR_W'(i), exp_words[i]);
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        test_reset();
        test_normal(1'b0, 1'b0);
        test_normal(1'b0, 1'b1);
        test_oversize();
        test_len0();
        test_len256();
        test_normal(1'b1, 1'b0);
        test_random_loads();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
